regfile_sb: RTL

//  Parametrised register file with synchronous clear, write-to-read bypass and a
//  per-register busy scoreboard for hazard detection. Two read ports and one write

---
 rtl/regfile_sb.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with synchronous clear, write-to-read bypass and a
// per-register busy scoreboard. Decode reads busy1/busy2 and iss_conflict to
// decide whether to stall. Issue reserves a destination and writeback releases it.
//
// Strobe semantics: the block has no valid/ready handshake. we3 and iss_en are
// single-cycle strobes that are always accepted on the posedge where they are
// high. The block never back-pressures. Stalling on busy1/busy2/iss_conflict is
// the caller's job, and an issue that reports a conflict is still applied.
//
// Debug: check exposes rf[checka] without bypass. busy_cnt exposes scoreboard
// occupancy.
module regfile_sb #(
  parameter int N        = 32,
  parameter int L        = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we3,
  input  logic [AW-1:0] wa3,
  input  logic [N-1:0]  wd3,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [N-1:0]  rd1,
  output logic [N-1:0]  rd2,
  output logic          busy1,
  output logic          busy2,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_a,
  output logic          iss_conflict,
  output logic [AW:0]   busy_cnt,
  input  logic [AW-1:0] checka,
  output logic [N-1:0]  check
);

  // Storage spans the full address space so any AW-bit index is in range.
  // Entries at or above L are never written and stay at zero.
  localparam int DEPTH = 1 << AW;

  logic [N-1:0]     rf [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_n;

  logic wr_ok;
  logic iss_set;
  logic cnt_inc;
  logic cnt_dec;

  // An address is architecturally present (and may hold data or be busy).
  function automatic logic valid_addr(input logic [AW-1:0] a);
    return (int'(a) < L) && !((a == '0) && (ZERO_REG != 0));
  endfunction

  assign wr_ok   = we3 && valid_addr(wa3);
  assign iss_set = iss_en && valid_addr(iss_a);

  // A new reservation counts only when the register was free. A release counts
  // only when the register was busy and no new producer claims it in the same
  // cycle.
  assign cnt_inc = iss_set && !busy[iss_a];
  assign cnt_dec = we3 && busy[wa3] && !(iss_set && (iss_a == wa3));

  // Register file storage: clear on reset, otherwise accept a valid writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (wr_ok) begin
      rf[wa3] <= wd3;
    end
  end

  // Scoreboard next state: set wins over clear. Invalid addresses stay free.
  always_comb begin
    busy_n = '0;
    for (int a = 0; a < DEPTH; a++) begin
      if (valid_addr(AW'(a))) begin
        busy_n[a] = (iss_set && (iss_a == AW'(a))) ||
                    (busy[a] && !(we3 && (wa3 == AW'(a))));
      end
    end
  end

  // Scoreboard state and occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_n;
      busy_cnt <= busy_cnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
    end
  end

  // Combinational read ports with same-cycle writeback bypass and hazard flags.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (valid_addr(ra1)) rd1 = (we3 && (wa3 == ra1)) ? wd3 : rf[ra1];
    if (valid_addr(ra2)) rd2 = (we3 && (wa3 == ra2)) ? wd3 : rf[ra2];
    busy1        = busy[ra1] && !(we3 && (wa3 == ra1));
    busy2        = busy[ra2] && !(we3 && (wa3 == ra2));
    iss_conflict = iss_en && valid_addr(iss_a) && busy[iss_a] &&
                   !(we3 && (wa3 == iss_a));
    check        = valid_addr(checka) ? rf[checka] : '0;
  end

endmodule
